// File: rtl/posit_pkg.sv
// Shared sizing helpers and the decoded-posit record for the posit decode scheduler.
// Pure declarations: no logic, no latency.
// Backpressure: not applicable.
package posit_pkg;

  // Regime k needs one bit beyond clog2(WIDTH) to hold the range -(WIDTH-1)..WIDTH-2.
  function automatic int rw_f(input int width);
    return $clog2(width) + 1;
  endfunction

  // Fraction width once sign, the two shortest-run regime bits and the exponent are removed.
  function automatic int fw_f(input int width, input int es);
    return width - 3 - es;
  endfunction

  // Requester index width. Keep it at least 1 bit so single-bit fields stay legal.
  function automatic int id_w_f(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int DEF_WIDTH = 16;
  localparam int DEF_ES    = 1;
  localparam int DEF_NREQ  = 2;

  // Decoded fields for the default 16-bit, es=1 configuration.
  typedef struct packed {
    logic                                     sign;
    logic signed [rw_f(DEF_WIDTH)-1:0]        regime;
    logic [DEF_ES-1:0]                        exp;
    logic [fw_f(DEF_WIDTH, DEF_ES)-1:0]       frac;
    logic                                     zero;
    logic                                     nar;
  } posit_dec_t;

endpackage

// File: rtl/posit_field_extract.sv
// Combinational posit field decode: sign, regime k, exponent and left-aligned fraction.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module posit_field_extract
  import posit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ES    = 1
) (
  input  logic [WIDTH-1:0]                  word,
  output logic                              sign,
  output logic signed [rw_f(WIDTH)-1:0]     regime,
  output logic [ES-1:0]                     exp,
  output logic [fw_f(WIDTH, ES)-1:0]        frac,
  output logic                              zero,
  output logic                              nar
);

  localparam int RW = rw_f(WIDTH);
  localparam int FW = fw_f(WIDTH, ES);

  logic [WIDTH-2:0] body;
  logic [WIDTH-2:0] flip;
  logic             r0;
  logic             hit;
  logic             special;
  logic [RW-1:0]    run;
  logic [WIDTH-4:0] tail;

  // Negate negative words, count the leading regime run, then shift out regime and terminator.
  always_comb begin
    special = ~|word[WIDTH-2:0];
    // Only the low WIDTH-1 bits of the two's complement are needed, so negate those alone.
    body    = word[WIDTH-1] ? (~word[WIDTH-2:0] + 1'b1) : word[WIDTH-2:0];
    r0      = body[WIDTH-2];
    flip    = r0 ? ~body : body;
    run     = '0;
    hit     = 1'b0;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (!hit) begin
        if (flip[i]) hit = 1'b1;
        else         run = run + 1'b1;
      end
    end
    // run >= 1 for any non-special word, so bits below the top two of body start after
    // run-1 further shifts; bits shifted past the LSB arrive as zeros.
    tail   = body[WIDTH-4:0] << (run - 1'b1);
    sign   = word[WIDTH-1];
    zero   = special & ~word[WIDTH-1];
    nar    = special & word[WIDTH-1];
    regime = '0;
    exp    = '0;
    frac   = '0;
    if (!special) begin
      regime = r0 ? $signed(run - 1'b1) : -$signed(run);
      exp    = tail[WIDTH-4 -: ES];
      frac   = tail[FW-1:0];
    end
  end

endmodule

// File: rtl/posit_decode_sched.sv
// Round-robin shares one posit field decoder among NREQ requesters; results tagged with id.
// Latency: 2 cycles accept->out_valid, 1 result/cycle sustained. Optional POSIT_DECODE_SCHED_STATS_EN counters.
// Backpressure: out_ready low holds S2, S1 then fills and req_ready drops to 0.
module posit_decode_sched
  import posit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ES    = 1,
  parameter int NREQ  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NREQ-1:0]                   req_valid,
  output logic [NREQ-1:0]                   req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0]        req_posit,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [id_w_f(NREQ)-1:0]           out_id,
  output logic                              out_sign,
  output logic signed [rw_f(WIDTH)-1:0]     out_regime,
  output logic [ES-1:0]                     out_exp,
  output logic [fw_f(WIDTH, ES)-1:0]        out_frac,
  output logic                              out_zero,
  output logic                              out_nar
`ifdef POSIT_DECODE_SCHED_STATS_EN
  ,
  output logic [NREQ-1:0][31:0]             stat_grants,
  output logic [31:0]                       stat_stall
`endif
);

  localparam int ID_W = id_w_f(NREQ);
  localparam int RW   = rw_f(WIDTH);
  localparam int FW   = fw_f(WIDTH, ES);

  typedef struct packed {
    logic                 sign;
    logic signed [RW-1:0] regime;
    logic [ES-1:0]        exp;
    logic [FW-1:0]        frac;
    logic                 zero;
    logic                 nar;
  } dec_t;

  logic [ID_W-1:0]  last_q, last_d;
  logic             s1_vld_q, s1_vld_d;
  logic [ID_W-1:0]  s1_id_q, s1_id_d;
  logic [WIDTH-1:0] s1_word_q, s1_word_d;
  logic             s2_vld_q, s2_vld_d;
  logic [ID_W-1:0]  s2_id_q, s2_id_d;
  dec_t             s2_dec_q, s2_dec_d;

  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  arb_idx;
  logic             found;
  logic             s1_adv;
  logic             s1_free;
  logic             accept;
  dec_t             dec;

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    arb_idx = '0;
    found   = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      arb_idx = ID_W'((int'(last_q) + 1 + j) % NREQ);
      if (!found && req_valid[arb_idx]) begin
        found         = 1'b1;
        grant[arb_idx] = 1'b1;
        gnt_id        = arb_idx;
      end
    end
  end

  assign s1_adv    = s1_vld_q & (~s2_vld_q | out_ready);
  assign s1_free   = ~s1_vld_q | s1_adv;
  // Held low during reset so nothing is offered while state is being cleared.
  assign req_ready = rst ? '0 : (grant & {NREQ{s1_free}});
  assign accept    = |req_ready;

  posit_field_extract #(
    .WIDTH (WIDTH),
    .ES    (ES)
  ) u_extract (
    .word   (s1_word_q),
    .sign   (dec.sign),
    .regime (dec.regime),
    .exp    (dec.exp),
    .frac   (dec.frac),
    .zero   (dec.zero),
    .nar    (dec.nar)
  );

  // Next-state for the rr pointer and both pipeline stages; S2 holds while stalled.
  always_comb begin
    last_d    = last_q;
    s1_vld_d  = s1_vld_q;
    s1_id_d   = s1_id_q;
    s1_word_d = s1_word_q;
    s2_vld_d  = s2_vld_q;
    s2_id_d   = s2_id_q;
    s2_dec_d  = s2_dec_q;
    if (accept) begin
      last_d    = gnt_id;
      s1_vld_d  = 1'b1;
      s1_id_d   = gnt_id;
      s1_word_d = req_posit[gnt_id];
    end else if (s1_adv) begin
      s1_vld_d  = 1'b0;
    end
    if (s1_adv) begin
      s2_vld_d = 1'b1;
      s2_id_d  = s1_id_q;
      s2_dec_d = dec;
    end else if (out_ready) begin
      s2_vld_d = 1'b0;
    end
  end

  // State registers; reset drops any in-flight words and points rr so requester 0 wins next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q    <= ID_W'(NREQ - 1);
      s1_vld_q  <= 1'b0;
      s1_id_q   <= '0;
      s1_word_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_id_q   <= '0;
      s2_dec_q  <= '0;
    end else begin
      last_q    <= last_d;
      s1_vld_q  <= s1_vld_d;
      s1_id_q   <= s1_id_d;
      s1_word_q <= s1_word_d;
      s2_vld_q  <= s2_vld_d;
      s2_id_q   <= s2_id_d;
      s2_dec_q  <= s2_dec_d;
    end
  end

  assign out_valid  = s2_vld_q;
  assign out_id     = s2_id_q;
  assign out_sign   = s2_dec_q.sign;
  assign out_regime = s2_dec_q.regime;
  assign out_exp    = s2_dec_q.exp;
  assign out_frac   = s2_dec_q.frac;
  assign out_zero   = s2_dec_q.zero;
  assign out_nar    = s2_dec_q.nar;

`ifdef POSIT_DECODE_SCHED_STATS_EN
  logic [NREQ-1:0][31:0] stat_grants_q, stat_grants_d;
  logic [31:0]           stat_stall_q, stat_stall_d;

  // Saturating per-requester accept counters and output stall counter.
  always_comb begin
    stat_grants_d = stat_grants_q;
    stat_stall_d  = stat_stall_q;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] && req_valid[i] && (stat_grants_q[i] != 32'hFFFF_FFFF))
        stat_grants_d[i] = stat_grants_q[i] + 32'd1;
    end
    if (s2_vld_q && !out_ready && (stat_stall_q != 32'hFFFF_FFFF))
      stat_stall_d = stat_stall_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_grants = stat_grants_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_posit_decode_sched.sv
// Bench for posit_decode_sched (WIDTH=16, ES=1, NREQ=2) with an accept-order scoreboard.
// Expected results come from an independent bit-walking posit decoder.
// Build with POSIT_DECODE_SCHED_STATS_EN to also exercise the counters.
module tb_posit_decode_sched;

  typedef struct packed {
    logic              id;
    logic              sign;
    logic signed [4:0] k;
    logic              e;
    logic [11:0]       f;
    logic              z;
    logic              n;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][15:0]  req_posit;
  logic              out_valid;
  logic              out_ready;
  logic [0:0]        out_id;
  logic              out_sign;
  logic signed [4:0] out_regime;
  logic [0:0]        out_exp;
  logic [11:0]       out_frac;
  logic              out_zero;
  logic              out_nar;
`ifdef POSIT_DECODE_SCHED_STATS_EN
  logic [1:0][31:0]  stat_grants;
  logic [31:0]       stat_stall;
`endif

  int   vecs = 0;
  int   errs = 0;
  int   cyc  = 0;
  exp_t sb[$];
  logic [15:0] src0[$];
  logic [15:0] src1[$];
  int   out_ids[$];
  int   out_cycs[$];

  posit_decode_sched #(.WIDTH(16), .ES(1), .NREQ(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_posit  (req_posit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_sign   (out_sign),
    .out_regime (out_regime),
    .out_exp    (out_exp),
    .out_frac   (out_frac),
    .out_zero   (out_zero),
    .out_nar    (out_nar)
`ifdef POSIT_DECODE_SCHED_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walks the bits one by one: regime run, terminator, exponent, then fraction.
  function automatic exp_t model(input logic [15:0] w, input int id);
    exp_t        r;
    logic [15:0] v;
    logic        r0;
    int          i;
    int          m;
    int          pos;
    r      = '0;
    r.id   = id[0];
    r.sign = w[15];
    if (w[14:0] == 15'd0) begin
      r.z = !w[15];
      r.n = w[15];
      return r;
    end
    v  = w[15] ? (~w + 16'd1) : w;
    r0 = v[14];
    m  = 0;
    i  = 14;
    while (i >= 0 && v[i] == r0) begin
      m++;
      i--;
    end
    r.k = r0 ? 5'(m - 1) : 5'(-m);
    pos = i - 1;
    r.e = (pos >= 0) ? v[pos] : 1'b0;
    pos--;
    for (int b = 11; b >= 0; b--) begin
      r.f[b] = (pos >= 0) ? v[pos] : 1'b0;
      pos--;
    end
    return r;
  endfunction

  // Scoreboard: push on every accepted request, pop and compare on every delivered result.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++)
        if (req_valid[i] && req_ready[i]) sb.push_back(model(req_posit[i], i));
      if (out_valid && out_ready) begin
        exp_t x;
        out_ids.push_back(int'(out_id));
        out_cycs.push_back(cyc);
        chk("sb_has_entry", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          x = sb.pop_front();
          chk("out_id",   {31'd0, out_id},   {31'd0, x.id});
          chk("out_sign", {31'd0, out_sign}, {31'd0, x.sign});
          chk("out_k",    out_regime,        x.k);
          chk("out_exp",  {31'd0, out_exp},  {31'd0, x.e});
          chk("out_frac", {20'd0, out_frac}, {20'd0, x.f});
          chk("out_zero", {31'd0, out_zero}, {31'd0, x.z});
          chk("out_nar",  {31'd0, out_nar},  {31'd0, x.n});
        end
      end
    end
  end

  // One cycle: drive out_ready and the queue heads after the edge, retire accepted words at negedge.
  task automatic step(input logic ordy);
    @(posedge clk);
    #1;
    out_ready    = ordy;
    req_valid[0] = (src0.size() > 0);
    req_valid[1] = (src1.size() > 0);
    if (src0.size() > 0) req_posit[0] = src0[0];
    if (src1.size() > 0) req_posit[1] = src1[0];
    @(negedge clk);
    if (req_valid[0] && req_ready[0]) void'(src0.pop_front());
    if (req_valid[1] && req_ready[1]) void'(src1.pop_front());
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src0.size() > 0 || src1.size() > 0 || sb.size() > 0) && n < budget) begin
      step(1'b1);
      n++;
    end
    chk("drain_done", {31'd0, (src0.size() == 0 && src1.size() == 0 && sb.size() == 0)}, 32'd1);
  endtask

  logic [22:0] snap;
  int          stall_seen;

  initial begin
    rst       = 1'b1;
    req_valid = 2'b11;
    req_posit = '0;
    out_ready = 1'b1;
    #3;
    // Reset state.
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_out_frac",  {20'd0, out_frac},  32'd0);
    chk("rst_out_k",     out_regime,         32'd0);
`ifdef POSIT_DECODE_SCHED_STATS_EN
    chk("rst_stat_stall", stat_stall, 32'd0);
`endif
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    // Test 1: first word latency, then the rest of the req0 sequence.
    @(posedge clk);
    #1;
    req_valid    = 2'b01;
    req_posit[0] = 16'h4000;
    @(negedge clk);
    chk("t1_ready", {30'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("t1_lat1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("t1_lat2", {31'd0, out_valid}, 32'd1);
    src0 = '{16'h5000, 16'h7FFF, 16'h0001};
    drain(40);

    // Test 2: negative, zero and NaR from req1.
    src1 = '{16'hC000, 16'h0000, 16'h8000};
    drain(40);

    // Test 3: both streaming, alternating ids at full rate.
    out_ids.delete();
    out_cycs.delete();
    for (int i = 0; i < 6; i++) begin
      src0.push_back(16'($urandom));
      src1.push_back(16'($urandom));
    end
    drain(100);
    chk("t3_count", out_ids.size(), 32'd12);
    if (out_ids.size() == 12) begin
      for (int i = 0; i < 12; i++) chk("t3_id_order", out_ids[i], i % 2);
      chk("t3_no_bubble", out_cycs[11] - out_cycs[0], 32'd11);
    end

    // Test 4: five stalled cycles with both requesters streaming.
    for (int i = 0; i < 6; i++) begin
      src0.push_back(16'($urandom));
      src1.push_back(16'($urandom));
    end
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    chk("t4_valid_at_stall", {31'd0, out_valid}, 32'd1);
    snap = {out_valid, out_id, out_sign, out_regime, out_exp, out_frac, out_zero, out_nar};
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      chk("t4_hold", {9'd0, out_valid, out_id, out_sign, out_regime, out_exp, out_frac, out_zero, out_nar},
          {9'd0, snap});
    end
    chk("t4_s1_full_ready", {30'd0, req_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      chk("t4_resume_no_gap", {31'd0, out_valid}, 32'd1);
    end
    drain(100);

    // Test 5: asynchronous reset while both stages hold data.
    src0 = '{16'h1234, 16'h2345, 16'h3456, 16'h4567};
    src1 = '{16'h9876, 16'h8765, 16'h7654, 16'h6543};
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    chk("t5_s2_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_s1_full", {30'd0, req_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_clear", {31'd0, out_valid}, 32'd0);
    sb.delete();
    src0.delete();
    src1.delete();
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      chk("t5_no_stale", {31'd0, out_valid}, 32'd0);
    end
    src0 = '{16'h4000};
    src1 = '{16'hC000};
    step(1'b1);
    chk("t5_first_grant", {30'd0, req_ready}, 32'd1);
    drain(40);

`ifdef POSIT_DECODE_SCHED_STATS_EN
    // Test 6: 3+2 accepts and exactly 4 stall cycles.
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    chk("t6_rst_grants0", stat_grants[0], 32'd0);
    src0 = '{16'h4000, 16'h5000, 16'h6000};
    src1 = '{16'hC000, 16'hB000};
    stall_seen = 0;
    for (int n = 0; n < 60; n++) begin
      if (src0.size() == 0 && src1.size() == 0 && sb.size() == 0 && stall_seen >= 4) break;
      step(stall_seen >= 4);
      if (out_valid && !out_ready) stall_seen++;
    end
    chk("t6_stalls_driven", stall_seen, 32'd4);
    chk("t6_grants0", stat_grants[0], 32'd3);
    chk("t6_grants1", stat_grants[1], 32'd2);
    chk("t6_stall",   stat_stall,     32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
